shift_rows: RTL and testbench
=============================

SHIFT_ROWS -- requirements
Module: shift_rows

Interface
REQ-001 Parameter: OUT_REG, default 1, 1 = registered output (1-cycle latency), 0 = combinational data path with registered out_valid only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  afterSub/inverse qualify this cycle.
REQ-005 inverse  input  1  0 = forward ShiftRows, 1 = InvShiftRows (only when SHIFT_ROWS_INV_EN defined).
REQ-006 afterSub  input  128  AES state after SubBytes.
REQ-007 out_valid  output  1  shifted holds a new result this cycle.
REQ-008 shifted  output  128  permuted AES state.

Function
REQ-009 State byte b(r,c), r = row 0..3, c = column 0..3, occupies bits [127-8*(4c+r) -: 8]; byte 0 = bits [127:120], column-major.
REQ-010 Forward: out(r,c) = in(r,(c+r) mod 4); row 0 unchanged, rows 1/2/3 rotated left by 1/2/3 bytes.
REQ-011 Inverse: out(r,c) = in(r,(c-r) mod 4); rows 1/2/3 rotated right by 1/2/3 bytes.
REQ-012 Pure byte permutation; no arithmetic, no byte value alteration.
REQ-013 OUT_REG=1: in_valid high at edge N -> shifted = permuted afterSub and out_valid = 1 after edge N.
REQ-014 OUT_REG=1: in_valid low at an edge -> shifted holds previous value, out_valid = 0 after that edge.
REQ-015 OUT_REG=0: shifted = permutation of current afterSub/inverse combinationally; out_valid = in_valid registered by one cycle.
REQ-016 Back-to-back in_valid every cycle: one result per cycle, no bubbles, no stall.
REQ-017 inverse sampled only when in_valid high; mode may change every cycle.

Reset
REQ-018 rst high at an edge: shifted = 128'h0, out_valid = 0 after that edge, regardless of in_valid.
REQ-019 rst has priority over in_valid; a transaction presented with rst high is discarded.
REQ-020 First valid result after reset release follows REQ-013 timing; no extra latency.

Configuration
REQ-021 Macro SHIFT_ROWS_INV_EN defined: inverse port honoured per REQ-011.
REQ-022 Macro SHIFT_ROWS_INV_EN undefined: inverse port present but ignored; forward permutation always; no inverse logic synthesized.

Verification
REQ-023 Forward, OUT_REG=1: afterSub=63C0AB20EB2F30CB9F93AF2BA092C7A2, in_valid=1 -> next cycle shifted=632FAFA2EB93C7209F92ABCBA0C0302B, out_valid=1.
REQ-024 Forward: afterSub=000102030405060708090A0B0C0D0E0F -> shifted=00050A0F04090E03080D02070C01060B.
REQ-025 Inverse (macro defined): afterSub=000102030405060708090A0B0C0D0E0F, inverse=1 -> shifted=000D0A0704010E0B0805020F0C090603; inverse of REQ-023 output returns 63C0AB20EB2F30CB9F93AF2BA092C7A2.
REQ-026 Hold: valid vector, then in_valid=0 for 3 cycles with changing afterSub -> shifted unchanged, out_valid=0.
REQ-027 Reset mid-stream: in_valid=1 continuous, rst=1 for one cycle -> shifted=0, out_valid=0 next cycle; following cycle resumes with correct result.
REQ-028 Macro undefined: REQ-025 stimulus with inverse=1 -> forward result 00050A0F04090E03080D02070C01060B.

Source files
------------

// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows byte permutation with optional output register.
// Ports: clk, rst (sync, active-high), in_valid, inverse, afterSub[127:0] in;
//   out_valid, shifted[127:0] out. Param OUT_REG: 1 = registered data path,
//   0 = combinational data with registered out_valid.
// Macro SHIFT_ROWS_INV_EN: when defined, inverse=1 selects InvShiftRows.
module shift_rows #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         inverse,
  input  logic [127:0] afterSub,
  output logic         out_valid,
  output logic [127:0] shifted
);

  logic         r_valid;
  logic [127:0] w_shifted;

`ifdef SHIFT_ROWS_INV_EN
  // Byte (r,c) sits at bits [127-8*(4c+r) -: 8]; the source column is
  // (c+r) mod 4 going forward and (c-r) mod 4 going backward.
  function automatic logic [127:0] f_perm(
    input logic [127:0] d,
    input logic         inv
  );
    logic [127:0] q;
    int           s;
    q = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s = inv ? ((c - r) & 3) : ((c + r) & 3);
        q[127-8*(4*c+r) -: 8] = d[127-8*(4*s+r) -: 8];
      end
    end
    return q;
  endfunction

  always_comb w_shifted = f_perm(afterSub, inverse);
`else
  function automatic logic [127:0] f_perm(
    input logic [127:0] d
  );
    logic [127:0] q;
    int           s;
    q = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s = (c + r) & 3;
        q[127-8*(4*c+r) -: 8] = d[127-8*(4*s+r) -: 8];
      end
    end
    return q;
  endfunction

  // Port kept for pin compatibility; the forward-only build ignores it.
  logic w_unused_inverse;
  assign w_unused_inverse = inverse;

  always_comb w_shifted = f_perm(afterSub);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_valid <= 1'b0;
    else     r_valid <= in_valid;
  end

  assign out_valid = r_valid;

  generate
    if (OUT_REG) begin : g_reg
      logic [127:0] r_shifted;
      always_ff @(posedge clk) begin
        if (rst)           r_shifted <= '0;
        else if (in_valid) r_shifted <= w_shifted;
      end
      assign shifted = r_shifted;
    end else begin : g_comb
      assign shifted = w_shifted;
    end
  endgenerate

endmodule

// File: tb/tb_shift_rows.sv
// Directed, table-driven bench for shift_rows: registered (OUT_REG=1) and
// combinational (OUT_REG=0) instances driven from the same stimulus.
module tb_shift_rows;

  localparam logic [127:0] A   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] F_A = 128'h00050A0F04090E03080D02070C01060B;
  localparam logic [127:0] I_A = 128'h000D0A0704010E0B0805020F0C090603;
  localparam logic [127:0] B   = 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2;
  localparam logic [127:0] F_B = 128'h632FAFA2EB93C7209F92ABCBA0C0302B;
  localparam logic [127:0] C   = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] F_C = 128'h10151A1F14191E13181D12171C11161B;
  localparam logic [127:0] I_C = 128'h101D1A1714111E1B1815121F1C191613;
  localparam logic [127:0] ONES = {128{1'b1}};

`ifdef SHIFT_ROWS_INV_EN
  localparam logic [127:0] X_A = I_A;
  localparam logic [127:0] X_C = I_C;
`else
  localparam logic [127:0] X_A = F_A;
  localparam logic [127:0] X_C = F_C;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         inverse;
  logic [127:0] afterSub;
  logic         out_valid;
  logic [127:0] shifted;
  logic         out_valid0;
  logic [127:0] shifted0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_rows #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inverse(inverse),
    .afterSub(afterSub), .out_valid(out_valid), .shifted(shifted)
  );

  shift_rows #(.OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inverse(inverse),
    .afterSub(afterSub), .out_valid(out_valid0), .shifted(shifted0)
  );

  typedef struct {
    logic         vld;
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp_reg;
    logic         exp_v;
    logic [127:0] exp_comb;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, B,    F_B,  1'b1, F_B};
    vt[1] = '{1'b1, 1'b0, A,    F_A,  1'b1, F_A};
    vt[2] = '{1'b1, 1'b1, A,    X_A,  1'b1, X_A};
    vt[3] = '{1'b1, 1'b0, C,    F_C,  1'b1, F_C};
    vt[4] = '{1'b1, 1'b1, C,    X_C,  1'b1, X_C};
    vt[5] = '{1'b0, 1'b0, A,    X_C,  1'b0, F_A};
    vt[6] = '{1'b0, 1'b0, B,    X_C,  1'b0, F_B};
    vt[7] = '{1'b0, 1'b1, ONES, X_C,  1'b0, ONES};
    vt[8] = '{1'b1, 1'b0, ONES, ONES, 1'b1, ONES};

    // Reset with a transaction presented: it must be discarded.
    rst = 1'b1; in_valid = 1'b1; inverse = 1'b0; afterSub = A;
    tick();
    tick();
    chk("rst_shifted", shifted, '0);
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_valid0", {127'd0, out_valid0}, 128'd0);

    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = vt[i].vld;
      inverse  = vt[i].inv;
      afterSub = vt[i].din;
      #1;
      chk($sformatf("v%0d_comb", i), shifted0, vt[i].exp_comb);
      tick();
      chk($sformatf("v%0d_shifted", i), shifted, vt[i].exp_reg);
      chk($sformatf("v%0d_valid", i), {127'd0, out_valid},
          {127'd0, vt[i].exp_v});
      chk($sformatf("v%0d_valid0", i), {127'd0, out_valid0},
          {127'd0, vt[i].exp_v});
    end

    // Reset mid-stream with in_valid held high, then resume.
    in_valid = 1'b1; inverse = 1'b0; afterSub = B;
    tick();
    chk("pre_rst", shifted, F_B);
    rst = 1'b1; afterSub = A;
    tick();
    chk("mid_rst_shifted", shifted, '0);
    chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_valid0", {127'd0, out_valid0}, 128'd0);
    rst = 1'b0;
    tick();
    chk("resume_shifted", shifted, F_A);
    chk("resume_valid", {127'd0, out_valid}, 128'd1);

`ifdef SHIFT_ROWS_INV_EN
    // Inverse of the forward result restores the original state.
    inverse = 1'b1; afterSub = F_B;
    tick();
    chk("roundtrip", shifted, B);
`endif

    in_valid = 1'b0; inverse = 1'b0;
    tick();
    chk("final_valid", {127'd0, out_valid}, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
